lcd1602_responder: RTL and testbench
====================================

Name: lcd1602_responder

Overview:
- Receive-side model of the LCD1602 write bus (E, RS, data[7:0]) driven by the piano top level.
- Decodes HD44780-subset commands and data writes into a 32-character shadow display buffer (2 rows x 16).
- Exposes the buffer, cursor and mode flags so the display content can be checked in simulation and mirrored on-board, for example to the dot matrix or an external debug port.
- Synthesizable; write-only bus with no RW or busy readback on the bus side.

Parameters:
- SYNC_STAGES, 2, synchroniser depth applied to E, RS and data.
- CLR_CHAR, 8'h20, fill character used by the clear command.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- E  in  1  LCD enable strobe; a transaction is latched on its falling edge.
- RS  in  1  register select: 0 = command, 1 = data.
- data  in  8  LCD data bus.
- rd_addr  in  5  buffer read index: [4] = row, [3:0] = column.
- rd_char  out  8  buffer[rd_addr]; registered, 1-cycle latency.
- cursor  out  7  current DDRAM address (0x00-0x0F or 0x40-0x4F).
- disp_on  out  1  display-on bit (D) from display control.
- two_line  out  1  N bit from function set.
- busy  out  1  high while a clear is in progress.
- wr_valid  out  1  1-cycle pulse per data write.
- wr_pos  out  5  buffer index written; valid with wr_valid.
- wr_char  out  8  character written; valid with wr_valid.
- overrun  out  1  sticky; set when an E falling edge arrives while busy.

Behaviour:
- Reset values (rst=0 at a clk edge): cursor=0, disp_on=0, two_line=0, busy=0, wr_valid=0, wr_pos=0, wr_char=0, overrun=0, rd_char=0, entry increment=1. Buffer contents after reset are undefined; a clear command is required before content is meaningful.
- Input capture:
  - E, RS and data each pass through SYNC_STAGES flops.
  - An edge pulse is generated when synchronised E goes 1->0.
  - RS and data are taken from the same synchronised stage as E.
- Latency: a transaction takes effect SYNC_STAGES+1 clk after the raw E falls, and is visible on outputs one cycle after that.
- FSM has two states, IDLE and CLEAR.
  - IDLE decodes each edge.
  - CLEAR writes CLR_CHAR to index 0..31, one entry per cycle (32 cycles), then sets cursor=0 and returns to IDLE.
  - busy=1 exactly while in CLEAR.
- Command decode (RS=0), highest set bit wins:
  - 1xxxxxxx: set DDRAM address. Cursor = data[6:0]. If the column is >0x0F or the address is not in row 0 or row 1, the value is clamped: row = data[6], column = 0.
  - 01xxxxxx: CGRAM address. Sets cg_mode; subsequent data writes are dropped until the next DDRAM-address, home or clear command.
  - 001xxxxx: function set; two_line = data[3].
  - 0001xxxx: shift. If S/C (data[3]) = 0, the cursor moves right when data[2]=1 and left otherwise, using the wrap rule below. If S/C=1, the command is ignored.
  - 00001xxx: display control; disp_on = data[2].
  - 000001xx: entry mode; increment = data[1]. The S bit is ignored.
  - 00000010 or 00000011: home; cursor=0, cg_mode=0.
  - 00000001: clear; cg_mode=0, increment=1, enter CLEAR.
  - 00000000: no operation.
- Data write (RS=1, not cg_mode):
  - buffer[idx(cursor)] = data.
  - wr_valid pulses with wr_pos=idx and wr_char=data.
  - The cursor then steps per increment.
- Wrap rule:
  - Increment: 0x0F -> 0x40, 0x4F -> 0x00.
  - Decrement: 0x40 -> 0x0F, 0x00 -> 0x4F.
- Edge while busy: the transaction is dropped and overrun is set. overrun clears only on reset.
- rd_addr read has lower priority than writes. A read and a write to the same index in the same cycle return the old value.
- Reset mid-CLEAR: abort immediately and apply reset values; busy=0 next cycle.

Decomposition:
- Shared package lcd_pkg holds:
  - Command opcode masks and values (CMD_CLEAR, CMD_HOME, CMD_ENTRY, CMD_DISPCTL, CMD_SHIFT, CMD_FUNC, CMD_CGRAM, CMD_DDRAM).
  - Row base addresses 7'h00 and 7'h40.
  - A cursor step function (increment/decrement with wrap).
  - An index function mapping cursor to [4:0].
- One sub-module, lcd_bus_sync: the SYNC_STAGES synchroniser plus E falling-edge detector, outputting edge, rs_s and data_s.

Test Plan:
- Reset, then command 0x01 -> busy high for 32 cycles. Afterwards every rd_addr returns 8'h20 and cursor=0; overrun stays 0.
- Send 0x38, 0x0C, 0x06 -> two_line=1, disp_on=1, increment=1. Then data 'P' (0x50) and 'N' (0x4E) -> wr_valid pulses at wr_pos 0 then 1; rd_addr 0 -> 0x50, rd_addr 1 -> 0x4E; cursor=0x02.
- Command 0x8F, then data 0x41, 0x42 -> buffer[15]=0x41, buffer[16]=0x42, cursor=0x41.
- Command 0x04 (decrement), 0x80, then data 0x58 -> buffer[0]=0x58, cursor=0x4F.
- Command 0x01, then an E falling edge 5 cycles later with data 0x31 -> write dropped, overrun=1. After the clear completes, buffer[0]=0x20.
- Command 0x40, data 0x33 -> no wr_valid and buffer unchanged. Then 0x02 and data 0x33 -> buffer[0]=0x33.
- Assert rst during the 10th CLEAR cycle -> next cycle busy=0, cursor=0, disp_on=0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD1602 receive-side model: command opcodes,
// row base addresses and the cursor stepping / indexing helpers.
package lcd_pkg;

   localparam logic [7:0] CMD_CLEAR   = 8'h01;
   localparam logic [7:0] CMD_HOME    = 8'h02;
   localparam logic [7:0] CMD_ENTRY   = 8'h04;
   localparam logic [7:0] CMD_DISPCTL = 8'h08;
   localparam logic [7:0] CMD_SHIFT   = 8'h10;
   localparam logic [7:0] CMD_FUNC    = 8'h20;
   localparam logic [7:0] CMD_CGRAM   = 8'h40;
   localparam logic [7:0] CMD_DDRAM   = 8'h80;

   localparam logic [6:0] ROW0_BASE = 7'h00;
   localparam logic [6:0] ROW1_BASE = 7'h40;
   localparam logic [6:0] ROW_LAST  = 7'h0F;

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } state_t;

   // An opcode matches when its leading one is the highest set bit of the byte.
   function automatic logic is_cmd(input logic [7:0] d, input logic [7:0] cmd);
      return (d & ~(cmd - 8'd1)) == cmd;
   endfunction

   function automatic logic [6:0] cursor_step(input logic [6:0] c, input logic inc);
      logic [6:0] r;
      if (inc) begin
         if (c == ROW0_BASE + ROW_LAST)
            r = ROW1_BASE;
         else if (c == ROW1_BASE + ROW_LAST)
            r = ROW0_BASE;
         else
            r = c + 7'd1;
      end else begin
         if (c == ROW1_BASE)
            r = ROW0_BASE + ROW_LAST;
         else if (c == ROW0_BASE)
            r = ROW1_BASE + ROW_LAST;
         else
            r = c - 7'd1;
      end
      return r;
   endfunction

   function automatic logic [4:0] cursor_idx(input logic [6:0] c);
      return {(c >= ROW1_BASE), c[3:0]};
   endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Synchronises the asynchronous LCD bus into the clk domain and flags the
// falling edge of E; RS and data come from the same stage as E.
module lcd_bus_sync
   import lcd_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       e,
   input  logic       rs,
   input  logic [7:0] data,
   output logic       e_edge,
   output logic       rs_s,
   output logic [7:0] data_s
);

   logic [SYNC_STAGES-1:0] e_sr;
   logic [SYNC_STAGES-1:0] rs_sr;
   logic [7:0]             data_sr [SYNC_STAGES];
   logic                   e_prev;

   always_ff @(posedge clk) begin
      if (!rst) begin
         e_sr   <= '0;
         rs_sr  <= '0;
         e_prev <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++)
            data_sr[i] <= 8'h00;
      end else begin
         e_sr[0]    <= e;
         rs_sr[0]   <= rs;
         data_sr[0] <= data;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            e_sr[i]    <= e_sr[i-1];
            rs_sr[i]   <= rs_sr[i-1];
            data_sr[i] <= data_sr[i-1];
         end
         e_prev <= e_sr[SYNC_STAGES-1];
      end
   end

   assign e_edge = e_prev & ~e_sr[SYNC_STAGES-1];
   assign rs_s   = rs_sr[SYNC_STAGES-1];
   assign data_s = data_sr[SYNC_STAGES-1];

endmodule

// File: rtl/lcd1602_responder.sv
// Shadow model of an HD44780-style 2x16 display: decodes bus writes into a
// 32-entry character buffer and exposes cursor, mode flags and write events.
module lcd1602_responder
   import lcd_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] CLR_CHAR    = 8'h20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       E,
   input  logic       RS,
   input  logic [7:0] data,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_char,
   output logic [6:0] cursor,
   output logic       disp_on,
   output logic       two_line,
   output logic       busy,
   output logic       wr_valid,
   output logic [4:0] wr_pos,
   output logic [7:0] wr_char,
   output logic       overrun
);

   logic       e_edge;
   logic       rs_s;
   logic [7:0] data_s;

   state_t     state, state_next;
   logic [4:0] clr_cnt;
   logic       increment;
   logic       cg_mode;

   logic [7:0] mem [32];
   logic       mem_we;
   logic [4:0] mem_addr;
   logic [7:0] mem_din;

   lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .rst    (rst),
      .e      (E),
      .rs     (RS),
      .data   (data),
      .e_edge (e_edge),
      .rs_s   (rs_s),
      .data_s (data_s)
   );

   always_ff @(posedge clk) begin
      if (!rst)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   // The clear sweep and data writes share the single buffer write port.
   always_comb begin
      state_next = state;
      mem_we     = 1'b0;
      mem_addr   = cursor_idx(cursor);
      mem_din    = data_s;
      case (state)
         ST_IDLE: begin
            if (e_edge && !rs_s && data_s == CMD_CLEAR)
               state_next = ST_CLEAR;
            if (e_edge && rs_s && !cg_mode)
               mem_we = 1'b1;
         end
         ST_CLEAR: begin
            mem_we   = 1'b1;
            mem_addr = clr_cnt;
            mem_din  = CLR_CHAR;
            if (clr_cnt == 5'd31)
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cursor    <= ROW0_BASE;
         disp_on   <= 1'b0;
         two_line  <= 1'b0;
         increment <= 1'b1;
         cg_mode   <= 1'b0;
         overrun   <= 1'b0;
         wr_valid  <= 1'b0;
         wr_pos    <= 5'd0;
         wr_char   <= 8'h00;
         clr_cnt   <= 5'd0;
      end else begin
         wr_valid <= 1'b0;
         if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 5'd1;
            if (clr_cnt == 5'd31)
               cursor <= ROW0_BASE;
            if (e_edge)
               overrun <= 1'b1;
         end else if (e_edge) begin
            if (rs_s) begin
               if (!cg_mode) begin
                  wr_valid <= 1'b1;
                  wr_pos   <= cursor_idx(cursor);
                  wr_char  <= data_s;
                  cursor   <= cursor_step(cursor, increment);
               end
            end else if (is_cmd(data_s, CMD_DDRAM)) begin
               // Addresses outside the two visible rows snap to column 0.
               cursor  <= (data_s[5:4] == 2'b00) ? data_s[6:0] : {data_s[6], 6'd0};
               cg_mode <= 1'b0;
            end else if (is_cmd(data_s, CMD_CGRAM)) begin
               cg_mode <= 1'b1;
            end else if (is_cmd(data_s, CMD_FUNC)) begin
               two_line <= data_s[3];
            end else if (is_cmd(data_s, CMD_SHIFT)) begin
               if (!data_s[3])
                  cursor <= cursor_step(cursor, data_s[2]);
            end else if (is_cmd(data_s, CMD_DISPCTL)) begin
               disp_on <= data_s[2];
            end else if (is_cmd(data_s, CMD_ENTRY)) begin
               increment <= data_s[1];
            end else if (is_cmd(data_s, CMD_HOME)) begin
               cursor  <= ROW0_BASE;
               cg_mode <= 1'b0;
            end else if (is_cmd(data_s, CMD_CLEAR)) begin
               cg_mode   <= 1'b0;
               increment <= 1'b1;
               clr_cnt   <= 5'd0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_addr] <= mem_din;
   end

   always_ff @(posedge clk) begin
      if (!rst)
         rd_char <= 8'h00;
      else
         rd_char <= mem[rd_addr];
   end

   assign busy = (state == ST_CLEAR);

endmodule

// File: tb/tb_lcd1602_responder.sv
// Self-checking bench for lcd1602_responder: directed scenarios plus random
// bus traffic checked against a row/column display model.
module tb_lcd1602_responder;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       E = 1'b0;
   logic       RS = 1'b0;
   logic [7:0] data = 8'h00;
   logic [4:0] rd_addr = 5'd0;
   logic [7:0] rd_char;
   logic [6:0] cursor;
   logic       disp_on, two_line, busy, wr_valid, overrun;
   logic [4:0] wr_pos;
   logic [7:0] wr_char;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mBuf [32];
   int          mRow, mCol;
   bit          mInc, mCg, mDisp, mTwo, mOver;
   logic [12:0] expWr[$];
   logic [12:0] gotWr[$];
   int          expIdx = 0;
   int          gotIdx = 0;
   int          busyTotal = 0;

   always #5 clk = ~clk;

   lcd1602_responder #(.SYNC_STAGES(2), .CLR_CHAR(8'h20)) dut (
      .clk      (clk),
      .rst      (rst),
      .E        (E),
      .RS       (RS),
      .data     (data),
      .rd_addr  (rd_addr),
      .rd_char  (rd_char),
      .cursor   (cursor),
      .disp_on  (disp_on),
      .two_line (two_line),
      .busy     (busy),
      .wr_valid (wr_valid),
      .wr_pos   (wr_pos),
      .wr_char  (wr_char),
      .overrun  (overrun)
   );

   // Monitor: log every write pulse and count busy cycles.
   always @(negedge clk) begin
      if (wr_valid)
         gotWr.push_back({wr_pos, wr_char});
      if (busy)
         busyTotal++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] mCursor();
      return mRow ? 7'(8'h40 + mCol) : 7'(mCol);
   endfunction

   task automatic modelReset();
      mRow = 0; mCol = 0; mInc = 1; mCg = 0; mDisp = 0; mTwo = 0; mOver = 0;
   endtask

   task automatic modelMove(input bit up);
      if (up) begin
         mCol++;
         if (mCol == 16) begin mCol = 0; mRow = 1 - mRow; end
      end else begin
         if (mCol == 0) begin mCol = 15; mRow = 1 - mRow; end
         else mCol--;
      end
   endtask

   task automatic modelApply(input bit rs, input logic [7:0] d);
      int msb = -1;
      if (rs) begin
         if (!mCg) begin
            mBuf[mRow*16 + mCol] = d;
            expWr.push_back({5'(mRow*16 + mCol), d});
            modelMove(mInc);
         end
         return;
      end
      for (int i = 7; i >= 0; i--)
         if (d[i] && msb < 0) msb = i;
      case (msb)
         7: begin
            mRow = d[6];
            mCol = int'(d[5:0]);
            if (mCol > 15) mCol = 0;
            mCg = 0;
         end
         6: mCg = 1;
         5: mTwo = d[3];
         4: if (!d[3]) modelMove(d[2]);
         3: mDisp = d[2];
         2: mInc = d[1];
         1: begin mRow = 0; mCol = 0; mCg = 0; end
         0: begin
            mCg = 0; mInc = 1; mRow = 0; mCol = 0;
            for (int i = 0; i < 32; i++) mBuf[i] = 8'h20;
         end
         default: ;
      endcase
   endtask

   task automatic applyStimulus(input bit rs, input logic [7:0] d);
      @(negedge clk);
      RS = rs; data = d; E = 1'b1;
      repeat (3) @(negedge clk);
      E = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic waitIdle();
      int n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("clear_done", busy, 0);
   endtask

   task automatic compareState(input string tag);
      checkOutput({tag, "_cursor"}, cursor, mCursor());
      checkOutput({tag, "_disp"}, disp_on, mDisp);
      checkOutput({tag, "_two"}, two_line, mTwo);
      checkOutput({tag, "_overrun"}, overrun, mOver);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_wrcount"}, gotWr.size(), expWr.size());
      while (gotIdx < gotWr.size() && expIdx < expWr.size()) begin
         checkOutput({tag, "_wr"}, gotWr[gotIdx], expWr[expIdx]);
         gotIdx++; expIdx++;
      end
      gotIdx = gotWr.size();
      expIdx = expWr.size();
   endtask

   task automatic doTxn(input bit rs, input logic [7:0] d);
      int b0 = busyTotal;
      applyStimulus(rs, d);
      modelApply(rs, d);
      if (!rs && d == 8'h01) begin
         waitIdle();
         @(negedge clk);
         checkOutput("busy_len", busyTotal - b0, 32);
      end
      compareState($sformatf("t%0d_%02h", rs, d));
   endtask

   task automatic readAt(input int idx, output logic [7:0] val);
      @(negedge clk);
      rd_addr = 5'(idx);
      @(negedge clk);
      val = rd_char;
   endtask

   task automatic scanBuffer(input string tag);
      logic [7:0] v;
      for (int i = 0; i < 32; i++) begin
         readAt(i, v);
         checkOutput($sformatf("%s_buf%0d", tag, i), v, mBuf[i]);
      end
   endtask

   initial begin
      logic [7:0] v;
      int b0, n;
      bit rsr;
      logic [7:0] dr;

      modelReset();
      for (int i = 0; i < 32; i++) mBuf[i] = 8'h00;
      repeat (3) @(negedge clk);
      checkOutput("rst_cursor", cursor, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_disp", disp_on, 0);
      checkOutput("rst_two", two_line, 0);
      checkOutput("rst_wrvalid", wr_valid, 0);
      checkOutput("rst_wrpos", wr_pos, 0);
      checkOutput("rst_wrchar", wr_char, 0);
      checkOutput("rst_overrun", overrun, 0);
      checkOutput("rst_rdchar", rd_char, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      doTxn(0, 8'h01);
      scanBuffer("clr");

      doTxn(0, 8'h38);
      doTxn(0, 8'h0C);
      doTxn(0, 8'h06);
      checkOutput("func_two", two_line, 1);
      checkOutput("disp_on", disp_on, 1);
      doTxn(1, 8'h50);
      doTxn(1, 8'h4E);
      checkOutput("cur_PN", cursor, 7'h02);
      readAt(0, v); checkOutput("rd_P", v, 8'h50);
      readAt(1, v); checkOutput("rd_N", v, 8'h4E);

      doTxn(0, 8'h8F);
      doTxn(1, 8'h41);
      doTxn(1, 8'h42);
      checkOutput("cur_wrap", cursor, 7'h41);
      readAt(15, v); checkOutput("rd_15", v, 8'h41);
      readAt(16, v); checkOutput("rd_16", v, 8'h42);

      doTxn(0, 8'h04);
      doTxn(0, 8'h80);
      doTxn(1, 8'h58);
      checkOutput("cur_dec", cursor, 7'h4F);
      readAt(0, v); checkOutput("rd_X", v, 8'h58);

      // A data write arriving mid-clear must be dropped and flagged.
      b0 = busyTotal;
      applyStimulus(0, 8'h01);
      modelApply(0, 8'h01);
      applyStimulus(1, 8'h31);
      mOver = 1;
      waitIdle();
      @(negedge clk);
      checkOutput("ovr_busy_len", busyTotal - b0, 32);
      compareState("ovr");
      readAt(0, v); checkOutput("ovr_buf0", v, 8'h20);

      doTxn(0, 8'h40);
      doTxn(1, 8'h33);
      readAt(0, v); checkOutput("cg_buf0", v, 8'h20);
      doTxn(0, 8'h02);
      doTxn(1, 8'h33);
      readAt(0, v); checkOutput("home_buf0", v, 8'h33);

      for (int k = 0; k < 150; k++) begin
         rsr = ($urandom_range(0, 9) < 6);
         dr = 8'($urandom);
         doTxn(rsr, dr);
      end
      scanBuffer("rand");

      // Reset asserted part way through a clear sweep.
      doTxn(0, 8'h0C);
      b0 = busyTotal;
      applyStimulus(0, 8'h01);
      n = 0;
      while ((busyTotal - b0) < 9 && n < 60) begin
         @(negedge clk);
         n++;
      end
      checkOutput("midclr_reached", busyTotal - b0, 9);
      rst = 1'b0;
      @(negedge clk);
      modelReset();
      checkOutput("midclr_busy", busy, 0);
      checkOutput("midclr_cursor", cursor, mCursor());
      checkOutput("midclr_disp", disp_on, mDisp);
      checkOutput("midclr_overrun", overrun, mOver);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("post_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
